// File: rtl/m_execute_pkg.sv
// Shared op codes, FSM states and op-class helpers
// for the iterative RV64M multiply/divide unit.
package m_execute_pkg;

  localparam logic [5:0] OP_MUL    = 6'd20;
  localparam logic [5:0] OP_MULH   = 6'd21;
  localparam logic [5:0] OP_MULHU  = 6'd22;
  localparam logic [5:0] OP_MULHSU = 6'd23;
  localparam logic [5:0] OP_DIV    = 6'd24;
  localparam logic [5:0] OP_DIVU   = 6'd25;
  localparam logic [5:0] OP_REM    = 6'd26;
  localparam logic [5:0] OP_REMU   = 6'd27;
  localparam logic [5:0] OP_MULW   = 6'd28;
  localparam logic [5:0] OP_DIVW   = 6'd29;
  localparam logic [5:0] OP_DIVUW  = 6'd30;
  localparam logic [5:0] OP_REMW   = 6'd31;
  localparam logic [5:0] OP_REMUW  = 6'd32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic op_valid(logic [5:0] op);
    return op >= OP_MUL && op <= OP_REMUW;
  endfunction

  function automatic logic op_is_w(logic [5:0] op);
    return op >= OP_MULW && op <= OP_REMUW;
  endfunction

  function automatic logic op_is_div(logic [5:0] op);
    return op inside {[OP_DIV:OP_REMU],
                      [OP_DIVW:OP_REMUW]};
  endfunction

  function automatic logic op_is_rem(logic [5:0] op);
    return op inside {OP_REM, OP_REMU,
                      OP_REMW, OP_REMUW};
  endfunction

  function automatic logic op_a_signed(logic [5:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV,
                      OP_REM, OP_DIVW, OP_REMW};
  endfunction

  function automatic logic op_b_signed(logic [5:0] op);
    return op inside {OP_MULH, OP_DIV, OP_REM,
                      OP_DIVW, OP_REMW};
  endfunction

endpackage

// File: rtl/m_div_serial.sv
// Restoring divider datapath, one quotient bit per step.
// Ports: clock/reset, load_i, step_i, dividend_i, divisor_i, quot_o, rem_o.
module m_div_serial #(
  parameter int W = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quot_o,
  output logic [W-1:0] rem_o
);

  logic [W-1:0] quot_q;
  logic [W-1:0] rem_q;
  logic [W-1:0] dvs_q;
  logic [W:0]   trial;

  // partial remainder can reach W+1 bits after the shift
  assign trial = {rem_q, quot_q[W-1]} - {1'b0, dvs_q};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (load_i) begin
      quot_q <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
    end else if (step_i) begin
      if (!trial[W]) begin
        rem_q  <= trial[W-1:0];
        quot_q <= {quot_q[W-2:0], 1'b1};
      end else begin
        rem_q  <= {rem_q[W-2:0], quot_q[W-1]};
        quot_q <= {quot_q[W-2:0], 1'b0};
      end
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/m_execute.sv
// Iterative RV64M multiply/divide unit (shift-add mul, restoring div).
// Ports: clock, reset(n), flush, req_*/ALU_operation/operands in, resp_*/result out.
module m_execute
  import m_execute_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [5:0]            ALU_operation,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  function automatic logic [W-1:0] sext32(logic [31:0] x);
    return {{(W-32){x[31]}}, x};
  endfunction

  state_t        state_q, state_d;
  logic [5:0]    op_q;
  logic          neg_q;
  logic [CW-1:0] cnt_q;
  logic [2*W-1:0] acc_q, mcand_q;
  logic [W-1:0]  mplier_q;
  logic [W-1:0]  result_q;

  logic          is_w, divf, is_rem, sa, sb;
  logic          b_zero, ovf, special, accept;
  logic [W-1:0]  a_src, b_src, a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag, dvd_in;
  logic [W-1:0]  spec_res, fix_res;
  logic [W-1:0]  quot, remv, quo_s, rem_s;
  logic [2*W-1:0] prod_s;

  assign is_w   = op_is_w(ALU_operation);
  assign divf   = op_is_div(ALU_operation);
  assign is_rem = op_is_rem(ALU_operation);

  assign sa = op_a_signed(ALU_operation)
            & (is_w ? operand_A[31] : operand_A[W-1]);
  assign sb = op_b_signed(ALU_operation)
            & (is_w ? operand_B[31] : operand_B[W-1]);

  assign a_src = is_w ? {{(W-32){1'b0}}, operand_A[31:0]}
                      : operand_A;
  assign b_src = is_w ? {{(W-32){1'b0}}, operand_B[31:0]}
                      : operand_B;
  assign a_neg = -a_src;
  assign b_neg = -b_src;

  // magnitudes; W-ops keep the upper half clear
  assign a_mag = !sa ? a_src
               : is_w ? {{(W-32){1'b0}}, a_neg[31:0]} : a_neg;
  assign b_mag = !sb ? b_src
               : is_w ? {{(W-32){1'b0}}, b_neg[31:0]} : b_neg;

  // W divides start with the 32-bit dividend in the top half,
  // so 32 steps leave the quotient in the low half
  assign dvd_in = is_w ? {a_mag[31:0], {(W-32){1'b0}}} : a_mag;

  assign b_zero = is_w ? (operand_B[31:0] == '0)
                       : (operand_B == '0);
  assign ovf = op_a_signed(ALU_operation) & divf
             & (is_w ? (operand_A[31:0] == 32'h8000_0000
                        && &operand_B[31:0])
                     : (operand_A == MIN_V && &operand_B));

  assign special = !op_valid(ALU_operation)
                 | (divf & (b_zero | ovf));

  always_comb begin
    spec_res = '0;
    if (op_valid(ALU_operation) && divf) begin
      if (b_zero) begin
        spec_res = !is_rem ? '1
                 : is_w ? sext32(operand_A[31:0]) : operand_A;
      end else if (ovf) begin
        spec_res = is_rem ? '0
                 : is_w ? sext32(32'h8000_0000) : MIN_V;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (req_valid) begin
          accept  = 1'b1;
          state_d = special ? S_DONE : S_CALC;
        end
        S_CALC: if (cnt_q == '0) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: if (resp_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  m_div_serial #(.W(W)) u_div (
    .clock      (clock),
    .reset      (reset),
    .load_i     (accept),
    .step_i     (state_q == S_CALC),
    .dividend_i (dvd_in),
    .divisor_i  (b_mag),
    .quot_o     (quot),
    .rem_o      (remv)
  );

  assign prod_s = neg_q ? -acc_q : acc_q;
  assign quo_s  = neg_q ? -quot : quot;
  assign rem_s  = neg_q ? -remv : remv;

  always_comb begin
    fix_res = '0;
    unique case (op_q)
      OP_MUL:  fix_res = prod_s[W-1:0];
      OP_MULH, OP_MULHU, OP_MULHSU:
               fix_res = prod_s[2*W-1:W];
      OP_MULW: fix_res = sext32(prod_s[31:0]);
      OP_DIV, OP_DIVU:     fix_res = quo_s;
      OP_REM, OP_REMU:     fix_res = rem_s;
      OP_DIVW, OP_DIVUW:   fix_res = sext32(quo_s[31:0]);
      OP_REMW, OP_REMUW:   fix_res = sext32(rem_s[31:0]);
      default: fix_res = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= ALU_operation;
        neg_q    <= is_rem ? sa : (sa ^ sb);
        cnt_q    <= is_w ? CW'(31) : CW'(W-1);
        acc_q    <= '0;
        mcand_q  <= {{W{1'b0}}, a_mag};
        mplier_q <= b_mag;
        if (special) result_q <= spec_res;
      end else if (!flush && state_q == S_CALC) begin
        if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
      if (!flush && state_q == S_FIX) result_q <= fix_res;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign result     = result_q;

endmodule

// File: tb/tb_m_execute.sv
// Self-checking bench for m_execute: vector table plus
// backpressure, flush and async-reset sequences.
module tb_m_execute;

  logic        clock = 1'b0;
  logic        reset, flush, req_valid, req_ready;
  logic        resp_valid, resp_ready;
  logic [5:0]  ALU_operation;
  logic [63:0] operand_A, operand_B, result;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  typedef struct {
    logic [5:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;
  vec_t vecs[$];

  always #5 clock = ~clock;

  m_execute dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .ALU_operation (ALU_operation),
    .operand_A     (operand_A),
    .operand_B     (operand_B),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .result        (result)
  );

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // present a request for one edge; operands scrambled afterwards
  task automatic send(input logic [5:0] op,
                      input logic [63:0] a,
                      input logic [63:0] b,
                      input logic [63:0] exp,
                      input bit push);
    ALU_operation = op;
    operand_A = a;
    operand_B = b;
    req_valid = 1'b1;
    if (push) sb_q.push_back(exp);
    tick();
    req_valid = 1'b0;
    ALU_operation = 6'($urandom);
    operand_A = {$urandom, $urandom};
    operand_B = {$urandom, $urandom};
  endtask

  // called just after the accept edge; n counts edges since then
  task automatic wait_valid(input string name, input int lat);
    int n = 0;
    logic [63:0] e;
    while (!resp_valid && n < 200) begin
      tick();
      n++;
    end
    check({name, "_lat"}, 64'(n), 64'(lat));
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    if (resp_valid) check({name, "_res"}, result, e);
    else check({name, "_res_timeout"}, 64'(resp_valid), 64'd1);
  endtask

  task automatic handshake(input string name);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({name, "_rv_drop"}, 64'(resp_valid), 64'd0);
    check({name, "_rdy"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int seen;
    vecs.push_back('{6'd20, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
                     64'hFFFF_FFFF_FFFF_FFEB, 65, "mul"});
    vecs.push_back('{6'd22, '1, '1,
                     64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu"});
    vecs.push_back('{6'd21, '1, '1, 64'd0, 65, "mulh_m1"});
    vecs.push_back('{6'd21, 64'h8000_0000_0000_0000,
                     64'h8000_0000_0000_0000,
                     64'h4000_0000_0000_0000, 65, "mulh_min"});
    vecs.push_back('{6'd23, '1, 64'd2, '1, 65, "mulhsu"});
    vecs.push_back('{6'd28, 64'h7FFF_FFFF, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFE, 33, "mulw"});
    vecs.push_back('{6'd28, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
                     64'hFFFF_FFFF_FFFF_FFF1, 33, "mulw_neg"});
    vecs.push_back('{6'd25, 64'd100, 64'd0, '1, 0, "divu_z"});
    vecs.push_back('{6'd26, 64'd100, 64'd0, 64'd100, 0, "rem_z"});
    vecs.push_back('{6'd24, 64'h8000_0000_0000_0000, '1,
                     64'h8000_0000_0000_0000, 0, "div_ovf"});
    vecs.push_back('{6'd26, 64'h8000_0000_0000_0000, '1,
                     64'd0, 0, "rem_ovf"});
    vecs.push_back('{6'd24, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFD, 65, "div_neg"});
    vecs.push_back('{6'd26, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                     '1, 65, "rem_neg"});
    vecs.push_back('{6'd27, 64'd100, 64'd7, 64'd2, 65, "remu"});
    vecs.push_back('{6'd30, 64'hFFFF_FFFF_0000_0010, 64'd4,
                     64'd4, 33, "divuw"});
    vecs.push_back('{6'd30, 64'hFFFF_FFFF, 64'd1, '1, 33,
                     "divuw_sext"});
    vecs.push_back('{6'd29, 64'h0000_0000_FFFF_FFF9, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFD, 33, "divw"});
    vecs.push_back('{6'd31, 64'h0000_0000_FFFF_FFF9, 64'd2,
                     '1, 33, "remw"});
    vecs.push_back('{6'd29, 64'h8000_0000, 64'hFFFF_FFFF,
                     64'hFFFF_FFFF_8000_0000, 0, "divw_ovf"});
    vecs.push_back('{6'd32, 64'h0000_0001_8000_0005,
                     64'h0000_0001_0000_0000,
                     64'hFFFF_FFFF_8000_0005, 0, "remuw_z"});
    vecs.push_back('{6'd33, 64'd9, 64'd3, 64'd0, 0, "bad33"});
    vecs.push_back('{6'd5, 64'd9, 64'd3, 64'd0, 0, "bad5"});

    reset = 1'b1;
    flush = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    ALU_operation = '0;
    operand_A = '0;
    operand_B = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_result", result, 64'd0);
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      check({vecs[i].name, "_pre_rdy"}, 64'(req_ready), 64'd1);
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
      wait_valid(vecs[i].name, vecs[i].lat);
      handshake(vecs[i].name);
    end

    // backpressure with a competing request held high
    send(6'd20, 64'd5, 64'd6, 64'd30, 1'b1);
    wait_valid("bp", 65);
    req_valid = 1'b1;
    ALU_operation = 6'd20;
    operand_A = 64'd2;
    operand_B = 64'd3;
    repeat (5) begin
      tick();
      check("bp_hold_res", result, 64'd30);
      check("bp_hold_rv", 64'(resp_valid), 64'd1);
      check("bp_hold_rdy", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp_hs_rv", 64'(resp_valid), 64'd0);
    check("bp_hs_rdy", 64'(req_ready), 64'd1);
    send(6'd20, 64'd2, 64'd3, 64'd6, 1'b1);
    wait_valid("bp2", 65);
    handshake("bp2");

    // flush in CALC
    send(6'd20, 64'd3, 64'd4, 64'd0, 1'b0);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_rdy", 64'(req_ready), 64'd1);
    check("flush_rv", 64'(resp_valid), 64'd0);
    check("flush_res", result, 64'd6);
    seen = 0;
    repeat (80) begin
      tick();
      if (resp_valid) seen = 1;
    end
    check("flush_noresp", 64'(seen), 64'd0);

    // flush alongside a request: not accepted
    req_valid = 1'b1;
    flush = 1'b1;
    ALU_operation = 6'd20;
    operand_A = 64'd1;
    operand_B = 64'd1;
    tick();
    req_valid = 1'b0;
    flush = 1'b0;
    check("flush_req_rdy", 64'(req_ready), 64'd1);
    check("flush_req_rv", 64'(resp_valid), 64'd0);

    // async reset mid-CALC
    send(6'd24, 64'd1000, 64'd3, 64'd0, 1'b0);
    repeat (20) tick();
    #2 reset = 1'b0;
    #1;
    check("arst_rv", 64'(resp_valid), 64'd0);
    check("arst_rdy", 64'(req_ready), 64'd1);
    check("arst_res", result, 64'd0);
    #2 reset = 1'b1;
    tick();
    seen = 0;
    repeat (70) begin
      tick();
      if (resp_valid) seen = 1;
    end
    check("arst_noresp", 64'(seen), 64'd0);
    check("arst_post_rdy", 64'(req_ready), 64'd1);
    send(6'd20, 64'd3, 64'd4, 64'd12, 1'b1);
    wait_valid("mul_after_rst", 65);
    handshake("mul_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
